// File: rtl/led_step_ctrl.sv
// led_step_ctrl: prescaled step sequencer driving an LED bar with WRAP/BOUNCE/SINGLE/FILL patterns.
// Optional macro LED_STEP_BLINK_EN blinks the frozen pattern while paused.
module led_step_ctrl #(
  parameter int NUM_LEDS = 10,
  parameter int PRE_DIV  = 10000,
  parameter int POS_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic                dir,
  input  logic [2:0]          speed,
  output logic [NUM_LEDS-1:0] LED,
  output logic [POS_W-1:0]    pos,
  output logic                busy,
  output logic                tick
);

  localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
  localparam logic [POS_W-1:0] LAST     = POS_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
  typedef enum logic [1:0] {M_WRAP, M_BOUNCE, M_SINGLE, M_FILL} mode_e;

  state_e             state_q;
  mode_e              mode_q;
  logic               dir_q;
  logic               bdir_q;
  logic [2:0]         speed_q;
  logic [2:0]         step_cnt_q;
  logic [POS_W-1:0]   pos_q;
  logic [PRE_W-1:0]   pre_cnt_q;
  logic               tick_q;
  logic [POS_W-1:0]   step_pos_d;
  logic               step_bdir_d;
  logic               single_end;
  logic [NUM_LEDS-1:0] pattern;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q    <= (pre_cnt_q == PRE_LAST);
      pre_cnt_q <= (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
    end
  end

  // Position the next step would move to; BOUNCE turns around at an endpoint in the same step.
  always_comb begin
    step_pos_d  = pos_q;
    step_bdir_d = bdir_q;
    single_end  = 1'b0;
    if (mode_q == M_BOUNCE) begin
      if (!bdir_q) begin
        if (pos_q == LAST) begin
          step_bdir_d = 1'b1;
          step_pos_d  = pos_q - 1'b1;
        end else begin
          step_pos_d  = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          step_bdir_d = 1'b0;
          step_pos_d  = pos_q + 1'b1;
        end else begin
          step_pos_d  = pos_q - 1'b1;
        end
      end
    end else if (!dir_q) begin
      if (pos_q == LAST) begin
        step_pos_d = '0;
        single_end = (mode_q == M_SINGLE);
      end else begin
        step_pos_d = pos_q + 1'b1;
      end
    end else begin
      if (pos_q == '0) begin
        step_pos_d = LAST;
        single_end = (mode_q == M_SINGLE);
      end else begin
        step_pos_d = pos_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= M_WRAP;
      dir_q      <= 1'b0;
      bdir_q     <= 1'b0;
      speed_q    <= '0;
      step_cnt_q <= '0;
      pos_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q    <= RUN;
            mode_q     <= mode_e'(mode);
            dir_q      <= dir;
            bdir_q     <= dir;
            speed_q    <= speed;
            step_cnt_q <= '0;
            pos_q      <= dir ? LAST : '0;
          end
        end
        RUN: begin
          // A stop landing on a step edge discards that step.
          if (stop) begin
            state_q <= PAUSE;
          end else if (tick_q) begin
            if (step_cnt_q == speed_q) begin
              step_cnt_q <= '0;
              if (single_end) begin
                state_q <= IDLE;
                pos_q   <= '0;
              end else begin
                pos_q   <= step_pos_d;
                bdir_q  <= step_bdir_d;
              end
            end else begin
              step_cnt_q <= step_cnt_q + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_q <= IDLE;
            pos_q   <= '0;
          end else if (start) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LED_STEP_BLINK_EN
  logic       blink_q;
  logic [2:0] blink_cnt_q;

  // Blink phase restarts lit on every entry to PAUSE and toggles every 8 ticks there.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (state_q != PAUSE) begin
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (tick_q) begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (blink_cnt_q == 3'd7) begin
        blink_q <= ~blink_q;
      end
    end
  end
`endif

  always_comb begin
    pattern = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (mode_q == M_FILL) begin
        pattern[i] = dir_q ? (i >= int'(pos_q)) : (i <= int'(pos_q));
      end else begin
        pattern[i] = (i == int'(pos_q));
      end
    end
  end

  always_comb begin
    LED = '0;
    if (state_q == RUN) begin
      LED = pattern;
    end else if (state_q == PAUSE) begin
`ifdef LED_STEP_BLINK_EN
      LED = pattern & {NUM_LEDS{blink_q}};
`else
      LED = pattern;
`endif
    end
  end

  assign pos  = pos_q;
  assign busy = (state_q != IDLE);
  assign tick = tick_q;

endmodule

// File: doc/led_step_ctrl.md
Name: led_step_ctrl

Overview:
- Sequencer for the 10-LED step display: generates step timing from `clk` and walks a position register through a selectable pattern.
- Decodes the position onto `LED[9:0]`.
- Start/stop inputs come from debounced, single-cycle board-button pulses.
- Sits between the button/switch front end and the board LED pins; replaces free-running stepping with controlled run, pause and idle.

Parameters:
- `NUM_LEDS`, 10, number of LEDs driven; 2..16.
- `PRE_DIV`, 10000, prescaler divide; `tick` every `PRE_DIV` clocks.
- `POS_W`, 4, width of `pos`; must satisfy 2^`POS_W` >= `NUM_LEDS`.

Ports:
- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse: run from IDLE, or resume from PAUSE.
- `stop`  in  1  single-cycle pulse: RUN->PAUSE, PAUSE->IDLE.
- `mode`  in  2  0 WRAP, 1 BOUNCE, 2 SINGLE, 3 FILL; latched on start from IDLE.
- `dir`  in  1  0 up (toward `LED[NUM_LEDS-1]`), 1 down; latched on start from IDLE.
- `speed`  in  3  step period = `PRE_DIV`*(`speed`+1) clocks; latched on start from IDLE.
- `LED`  out  `NUM_LEDS`  LED drive, 1 = lit.
- `pos`  out  `POS_W`  current position.
- `busy`  out  1  high in RUN or PAUSE.
- `tick`  out  1  prescaler strobe, one cycle wide.

Behaviour:
- Reset (sync, `rst`=1 at posedge):
  - State IDLE.
  - `pos`=0, `LED`=0, `busy`=0, `tick`=0.
  - Prescaler, step counter and latched mode/dir/speed all cleared.
  - Reset mid-RUN or mid-PAUSE takes effect at that edge, with no completion of the current step.
- Prescaler:
  - `pre_cnt` counts 0..`PRE_DIV`-1 and wraps.
  - Free-running in every state except reset.
  - `tick` is registered and high for the one cycle after `pre_cnt`==`PRE_DIV`-1.
- Step counter: active only in RUN.
  - On `tick`: if `step_cnt`==latched `speed`, a step occurs and `step_cnt`<=0; else `step_cnt`+1.
  - `step_cnt` is cleared on entry to RUN from IDLE.
  - `step_cnt` is held, not cleared, across PAUSE.
- FSM states IDLE, RUN, PAUSE:
  - IDLE + `start` -> RUN. Latch mode/dir/speed. `pos` <= 0 if `dir`=0, else `NUM_LEDS`-1. Internal `bdir` <= `dir`.
  - RUN + `stop` -> PAUSE.
  - RUN + SINGLE end reached -> IDLE.
  - PAUSE + `start` -> RUN, resuming `pos`/`step_cnt`/`bdir` unchanged.
  - PAUSE + `stop` -> IDLE, `pos`<=0.
  - `start` and `stop` in the same cycle: `stop` wins.
  - `start` in RUN and `stop` in IDLE are ignored.
  - `mode`/`dir`/`speed` changes while `busy` are ignored until the next start from IDLE.
- Step actions, per latched mode:
  - WRAP: up: `pos`+1, `NUM_LEDS`-1 wraps to 0. Down: `pos`-1, 0 wraps to `NUM_LEDS`-1.
  - BOUNCE: move in `bdir`. At an endpoint, reverse `bdir` and move one step in the new direction the same cycle; endpoints are never shown twice in a row.
  - SINGLE: as WRAP. A step from the last position (`NUM_LEDS`-1 up / 0 down) goes to IDLE with `pos`<=0 instead of wrapping.
  - FILL: position update as WRAP; only the decode differs.
- `LED` decode (combinational from registers, same cycle as `pos`):
  - IDLE: all 0.
  - WRAP/BOUNCE/SINGLE: one-hot at `pos`.
  - FILL up: bits 0..`pos` set.
  - FILL down: bits `pos`..`NUM_LEDS`-1 set.
  - PAUSE shows the frozen pattern.
- `busy` = (state != IDLE), combinational from state.
- A step and a `stop` in the same cycle: the step is discarded, `pos` is unchanged, and the block enters PAUSE.

Optional Feature:
- Macro `LED_STEP_BLINK_EN`.
- Defined: in PAUSE, `LED` = frozen pattern AND `blink`, where `blink` is a flop toggling every 8 `tick`s. `blink` is set to 1 on entry to PAUSE. Its counter is cleared on reset and while not in PAUSE.
- Undefined: PAUSE shows a steady frozen pattern; no blink logic is instantiated.

Test Plan (`PRE_DIV`=4, `NUM_LEDS`=10):
- Reset: hold `rst` 3 cycles, release -> `LED`=0, `pos`=0, `busy`=0. `tick` is first seen 4 cycles after release, then every 4 cycles.
- WRAP up, `speed`=0:
  - `start` pulse -> `busy`=1, `LED`=0x001.
  - Steps occur every 4 clocks: `pos` 1,2,..,9, then 0.
  - `LED`=0x200 then 0x001 at the wrap.
- BOUNCE up, `speed`=1: steps every 8 clocks, `pos` sequence 0,1,..,9,8,7,..,0,1, with no repeated endpoint.
- SINGLE down, `speed`=0:
  - `pos` sequence 9,8,..,0.
  - Next step -> IDLE: `busy`=0, `LED`=0.
  - A later `start` restarts at 9.
- FILL up, pause/resume, `speed`=2:
  - After 3 steps, `LED`=0x00F.
  - `stop` -> `busy`=1, `LED` holds 0x00F for 40 clocks.
  - `start` -> next step gives 0x01F.
  - `stop`,`stop` -> IDLE, `LED`=0.
- Collisions: `start`+`stop` same cycle in RUN -> PAUSE. `mode` change while RUN has no effect. `rst` mid-RUN at `pos`=5 -> `pos`=0, `LED`=0 at that edge.
